// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: writeback, read ports, reservation and flush.
// master = core issue/writeback side, slave = register file.
interface regfile_sb_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);
  logic                         write_enable;
  logic [ADDR_WIDTH-1:0]        rd_address;
  logic [XLEN-1:0]              rd_data;
  logic [NUM_READ*ADDR_WIDTH-1:0] read_address;
  logic [NUM_READ*XLEN-1:0]     read_data;
  logic [NUM_READ-1:0]          read_busy;
  logic                         reserve_enable;
  logic [ADDR_WIDTH-1:0]        reserve_address;
  logic                         reserve_accept;
  logic                         flush;
  logic [ADDR_WIDTH:0]          pending_count;

  modport master (
    output write_enable, rd_address, rd_data, read_address,
    output reserve_enable, reserve_address, flush,
    input  read_data, read_busy, reserve_accept, pending_count
  );

  modport slave (
    input  write_enable, rd_address, rd_data, read_address,
    input  reserve_enable, reserve_address, flush,
    output read_data, read_busy, reserve_accept, pending_count
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with a per-register pending scoreboard.
// Issue reserves a destination, writeback releases it, flush drops all reservations.
module regfile_sb #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic         clock,
  input  logic         reset,
  regfile_sb_if.slave  bus
);
  localparam int NREGS      = 2 ** ADDR_WIDTH;
  localparam int CW         = ADDR_WIDTH + 1;
  localparam bit USE_BYPASS = (BYPASS != 0);
  localparam bit USE_ZERO   = (ZERO_REG != 0);

  // Power-up values make reads return zero even before the first reset.
  logic [XLEN-1:0]  regs_reg [NREGS] = '{default: '0};
  logic [NREGS-1:0] pending_reg = '0;
  logic [NREGS-1:0] pending_next;
  logic [CW-1:0]    count_reg = '0;
  logic [CW-1:0]    count_next;
  logic             write_allowed;
  logic             reserve_zero;
  logic             accept;

  assign write_allowed = bus.write_enable && !(USE_ZERO && (bus.rd_address == '0));
  assign reserve_zero  = USE_ZERO && (bus.reserve_address == '0);

  // Judged against the current pending bit only, so there is no path from the write port.
  assign accept = bus.reserve_enable && !pending_reg[bus.reserve_address]
                  && !bus.flush && !reserve_zero;

  assign bus.reserve_accept = accept;
  assign bus.pending_count  = count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (write_allowed) begin
      regs_reg[bus.rd_address] <= bus.rd_data;
    end
  end

  // Priority: release, then flush, then reserve, so a same-cycle reserve wins.
  always_comb begin
    pending_next = pending_reg;
    if (bus.write_enable) begin
      pending_next[bus.rd_address] = 1'b0;
    end
    if (bus.flush) begin
      pending_next = '0;
    end
    if (accept) begin
      pending_next[bus.reserve_address] = 1'b1;
    end
  end

  always_comb begin
    count_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      count_next = count_next + CW'(pending_next[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_reg <= '0;
      count_reg   <= '0;
    end else begin
      pending_reg <= pending_next;
      count_reg   <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [ADDR_WIDTH-1:0] addr;
      logic [XLEN-1:0]       data;
      logic                  busy;

      assign addr = bus.read_address[gi*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
        data = regs_reg[addr];
        busy = pending_reg[addr];
        if (USE_ZERO && (addr == '0)) begin
          data = '0;
          busy = 1'b0;
        end else if (USE_BYPASS && bus.write_enable && (bus.rd_address == addr)) begin
          data = bus.rd_data;
          busy = 1'b0;
        end
      end

      assign bus.read_data[gi*XLEN +: XLEN] = data;
      assign bus.read_busy[gi]              = busy;
    end
  endgenerate
endmodule
